// File: rtl/field_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : field_seq_pkg
//  Purpose  : Shared types and constants for the field extract sequencer.
//             state_e : sequencer FSM states
//             dir_e   : field walk direction (ascending / descending)
//  Revision : 1.0 - initial release
// ============================================================================
package field_seq_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int IDX_W          = $clog2(DATA_W_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage
`default_nettype wire

// File: rtl/field_extract_sequencer_rot.sv
`default_nettype none
// ============================================================================
//  Module   : rot_field_extract
//  Purpose  : Combinational rotate-and-select of one FIELD_W-bit field from a
//             DATA_W-bit word, with indices taken modulo DATA_W.
//  Ports    : i_word  - source word
//             i_idx   - anchor bit index
//             i_dir   - DIR_UP: [idx +: FIELD_W], DIR_DOWN: [idx -: FIELD_W]
//             o_field - selected field (MSB = highest-numbered source bit)
//             o_wrap  - field crosses the bit DATA_W-1 / bit 0 boundary
//  Revision : 1.0 - initial release
// ============================================================================
module rot_field_extract
    import field_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FIELD_W = 8
) (
    input  logic [DATA_W-1:0]         i_word,
    input  logic [$clog2(DATA_W)-1:0] i_idx,
    input  dir_e                      i_dir,
    output logic [FIELD_W-1:0]        o_field,
    output logic                      o_wrap
);

    localparam int                 c_IDX_W = $clog2(DATA_W);
    localparam logic [c_IDX_W-1:0] c_BACK  = c_IDX_W'(FIELD_W - 1);

    logic [c_IDX_W-1:0] w_base;

    always_comb begin
        // Lowest source bit of the field; a descending field ends at idx.
        w_base  = (i_dir == DIR_DOWN) ? (i_idx - c_BACK) : i_idx;
        o_field = '0;
        // Index sum is IDX_W bits wide, so it wraps modulo DATA_W for free.
        for (int i = 0; i < FIELD_W; i++) begin
            o_field[i] = i_word[w_base + c_IDX_W'(i)];
        end
        if (i_dir == DIR_DOWN) begin
            o_wrap = (int'(i_idx) < FIELD_W - 1);
        end else begin
            o_wrap = (int'(i_idx) + FIELD_W > DATA_W);
        end
    end

endmodule
`default_nettype wire

// File: rtl/field_extract_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : field_extract_sequencer
//  Purpose  : Captures one command word and emits i_cmd_count fields from it,
//             one per output handshake, walking up or down from i_cmd_start.
//  Ports    : clk, rst (sync, active high)
//             i_cmd_valid/o_cmd_ready, i_cmd_data, i_cmd_start, i_cmd_dir,
//             i_cmd_count      - command channel
//             i_flush          - abort current command
//             o_out_valid/i_out_ready, o_out_field, o_out_last, o_out_wrap
//                              - field stream
//             o_done           - one-cycle pulse at command completion
//  Revision : 1.0 - initial release
// ============================================================================
module field_extract_sequencer
    import field_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FIELD_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [DATA_W-1:0]         i_cmd_data,
    input  logic [$clog2(DATA_W)-1:0] i_cmd_start,
    input  logic                      i_cmd_dir,
    input  logic [CNT_W-1:0]          i_cmd_count,
    input  logic                      i_flush,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [FIELD_W-1:0]        o_out_field,
    output logic                      o_out_last,
    output logic                      o_out_wrap,
    output logic                      o_done
);

    localparam int                 c_IDX_W = $clog2(DATA_W);
    localparam logic [c_IDX_W-1:0] c_STEP  = c_IDX_W'(FIELD_W % DATA_W);

    state_e              r_state;
    logic [DATA_W-1:0]   r_word;
    logic [c_IDX_W-1:0]  r_idx;
    dir_e                r_dir;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_valid;
    logic [FIELD_W-1:0]  r_field;
    logic                r_last;
    logic                r_wrap;
    logic                r_done;

    logic [c_IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0]   w_ext_word;
    logic [c_IDX_W-1:0]  w_ext_idx;
    dir_e                w_ext_dir;
    logic [FIELD_W-1:0]  w_field;
    logic                w_wrap;

    // The single extractor looks at the incoming command while idle (first
    // field) and at the captured word with the next index while running.
    always_comb begin
        w_idx_next = (r_dir == DIR_DOWN) ? (r_idx - c_STEP) : (r_idx + c_STEP);
        if (r_state == IDLE) begin
            w_ext_word = i_cmd_data;
            w_ext_idx  = i_cmd_start;
            w_ext_dir  = dir_e'(i_cmd_dir);
        end else begin
            w_ext_word = r_word;
            w_ext_idx  = w_idx_next;
            w_ext_dir  = r_dir;
        end
    end

    rot_field_extract #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W)
    ) u_extract (
        .i_word  (w_ext_word),
        .i_idx   (w_ext_idx),
        .i_dir   (w_ext_dir),
        .o_field (w_field),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_dir   <= DIR_UP;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_field <= '0;
            r_last  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                // Abort wins over any same-cycle handshake or accept.
                r_state <= IDLE;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_cmd_valid) begin
                            r_word <= i_cmd_data;
                            r_idx  <= i_cmd_start;
                            r_dir  <= dir_e'(i_cmd_dir);
                            r_cnt  <= i_cmd_count;
                            if (i_cmd_count != '0) begin
                                r_state <= RUN;
                                r_valid <= 1'b1;
                                r_field <= w_field;
                                r_wrap  <= w_wrap;
                                r_last  <= (i_cmd_count == CNT_W'(1));
                            end else begin
                                r_state <= DRAIN;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (i_out_ready) begin
                            if (r_last) begin
                                r_state <= DRAIN;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx   <= w_idx_next;
                                r_cnt   <= r_cnt - CNT_W'(1);
                                r_field <= w_field;
                                r_wrap  <= w_wrap;
                                r_last  <= (r_cnt == CNT_W'(2));
                            end
                        end
                    end
                    DRAIN: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready = (r_state == IDLE) && !rst;
    assign o_out_valid = r_valid;
    assign o_out_field = r_field;
    assign o_out_last  = r_last;
    assign o_out_wrap  = r_wrap;
    assign o_done      = r_done;

endmodule
`default_nettype wire
